// File: rtl/div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl
//
// Control FSM for an 8-bit restoring divider. The FSM sequences an external
// datapath (operand registers, partial remainder R, quotient Q and output
// registers) through load, divisor-zero check, eight shift/test iterations,
// output load and a one-cycle completion pulse.
//
// Ports
//   clk     in   clock; all state changes on the rising edge
//   rst     in   asynchronous active-low reset
//   start   in   request a new divide; sampled only in IDLE
//   abort   in   synchronous cancel of an operation in progress
//   d_zero  in   datapath flag: loaded divisor == 0 (valid in CHECK)
//   r_ge_d  in   datapath flag: shifted remainder >= divisor (valid in TEST)
//   ld      out  load operands into datapath registers
//   clr     out  clear partial remainder
//   shf     out  shift {R,Q} left by one
//   sub     out  write R - D back into R      (Mealy, TEST only)
//   qset    out  set Q[0]                     (Mealy, TEST only)
//   ld2     out  load output registers
//   busy    out  operation in progress (any state except IDLE)
//   done    out  one-cycle completion pulse (normal or divide-by-zero)
//   err     out  divide-by-zero flag, sticky until the next accepted start
//   cnt     out  current iteration index, 0..7
// ---------------------------------------------------------------------------
module div_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       d_zero,
    input  logic       r_ge_d,
    output logic       ld,
    output logic       clr,
    output logic       shf,
    output logic       sub,
    output logic       qset,
    output logic       ld2,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        SHIFT,
        TEST,
        OUT,
        DONE,
        ERR
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'd7;

    state_t     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       err_q,   err_d;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (abort && (state_q != IDLE)) begin
            // Abort overrides every busy state; cnt and err are left alone.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // abort=1 in IDLE blocks start.
                    if (start && !abort) begin
                        state_d = LOAD;
                        err_d   = 1'b0;
                    end
                end
                LOAD: begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end
                CHECK: begin
                    if (d_zero) begin
                        // err is raised on entry so it is already visible
                        // during the ERR cycle, together with done.
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    state_d = TEST;
                end
                TEST: begin
                    if (cnt_q == LAST_ITER) begin
                        state_d = OUT;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = SHIFT;
                    end
                end
                OUT: begin
                    state_d = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                ERR: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode: Moore outputs from state_q only; sub/qset are the sole
    // Mealy outputs and depend on r_ge_d in TEST.
    // -----------------------------------------------------------------------
    always_comb begin
        ld   = 1'b0;
        clr  = 1'b0;
        shf  = 1'b0;
        sub  = 1'b0;
        qset = 1'b0;
        ld2  = 1'b0;
        done = 1'b0;
        busy = (state_q != IDLE);

        case (state_q)
            LOAD: begin
                ld  = 1'b1;
                clr = 1'b1;
            end
            SHIFT: begin
                shf = 1'b1;
            end
            TEST: begin
                sub  = r_ge_d;
                qset = r_ge_d;
            end
            OUT: begin
                ld2 = 1'b1;
            end
            DONE, ERR: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign err = err_q;
    assign cnt = cnt_q;

endmodule

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows:
  clk      in   1  clock; all state changes on the rising edge
  rst      in   1  asynchronous active-low reset
  start    in   1  request a new 8-bit divide; sampled only in IDLE
  abort    in   1  synchronous cancel of an operation in progress
  d_zero   in   1  datapath flag: loaded divisor == 0; valid in CHECK
  r_ge_d   in   1  datapath flag: shifted partial remainder >= divisor; valid in TEST
  ld       out  1  load din_N/din_D into datapath operand registers
  clr      out  1  clear datapath partial remainder
  shf      out  1  shift datapath {R,Q} left by one bit
  sub      out  1  write R - D back into R
  qset     out  1  set Q[0] to 1
  ld2      out  1  load dout_R/dout_Q output registers
  busy     out  1  operation in progress
  done     out  1  one-cycle completion pulse
  err      out  1  divide-by-zero flag; sticky until next accepted start
  cnt      out  4  current iteration index, 0..7

Function
REQ-002 The FSM SHALL have exactly these states: IDLE, LOAD, CHECK, SHIFT, TEST, OUT, DONE, ERR.
REQ-003 IDLE with start=1 and abort=0 SHALL move to LOAD and clear err; otherwise it SHALL stay in IDLE.
REQ-004 LOAD SHALL assert ld and clr for one cycle, reset cnt to 0, and move to CHECK.
REQ-005 CHECK SHALL move to ERR if d_zero=1, otherwise to SHIFT.
REQ-006 SHIFT SHALL assert shf for one cycle and move to TEST.
REQ-007 TEST SHALL assert sub and qset combinationally in the same cycle exactly when r_ge_d=1; these two outputs are the only Mealy outputs.
REQ-008 TEST SHALL move to OUT when cnt=7 and otherwise increment cnt and return to SHIFT.
REQ-009 OUT SHALL assert ld2 for one cycle and move to DONE.
REQ-010 DONE SHALL assert done for one cycle and move to IDLE.
REQ-011 ERR SHALL set err, assert done for one cycle, never assert ld2, and move to IDLE.
REQ-012 All outputs other than sub and qset SHALL be decoded from the state register only; every output not named for a state SHALL be 0 in that state.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 Latency: if start is sampled at edge 0, done SHALL be high in the cycle after edge 19 (LOAD 1 + CHECK 1 + 8x(SHIFT+TEST) 16 + OUT 1 + DONE 1).
REQ-015 Divide-by-zero latency: done and err SHALL be high in the cycle after edge 2.
REQ-016 start asserted in any state other than IDLE, including DONE, SHALL be ignored and SHALL NOT be queued.
REQ-017 abort=1 in any busy state SHALL move to IDLE at the next edge, with no done and no ld2, and err unchanged.
REQ-018 abort and start both high in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-019 cnt SHALL be 4 bits wide, hold its value outside LOAD and TEST, and never exceed 7.

Reset
REQ-020 rst=0 SHALL immediately force state=IDLE, cnt=0, err=0, and all control outputs, busy and done to 0, regardless of clk.
REQ-021 Reset asserted mid-operation SHALL abandon the operation without a done pulse; after release, the first edge with start=1 SHALL begin a normal LOAD.

Verification
REQ-022 The bench SHALL pair the block with a behavioural restoring-divider datapath model and cover these scenarios:
  - N=100, D=7 -> qset high at cnt=4,5,6 only; done 20 cycles after start; model yields Q=14, R=2; err=0.
  - N=255, D=1 -> qset at every TEST (8 pulses); Q=255, R=0; exactly one ld2 pulse.
  - D=0 -> err=1 and done together, 3 cycles after start; shf never asserted; ld2 never asserted; err stays 1 until next start.
  - abort at cycle 10 -> busy=0 next cycle; no done, no ld2; a following start with N=9, D=3 gives Q=3, R=0.
  - start held high through an entire operation -> exactly one operation and one done; a new LOAD follows only from IDLE.
  - rst pulsed low mid-TEST -> outputs 0 immediately; no done; a clean restart yields the correct result.
